// File: rtl/mul_issue_ctrl.sv
// Round-robin issue controller sharing one non-stalling pipelined multiplier between two
// requesters, with credit-gated issue, an in-flight tracker and an in-order response FIFO.
module mul_issue_ctrl #(
    parameter int WORD_WIDTH  = 32,
    parameter int TAG_WIDTH   = 4,
    parameter int MUL_LATENCY = 5,
    parameter int RESP_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [WORD_WIDTH-1:0] req0_a,
    input  logic [WORD_WIDTH-1:0] req0_b,
    input  logic [TAG_WIDTH-1:0]  req0_tag,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [WORD_WIDTH-1:0] req1_a,
    input  logic [WORD_WIDTH-1:0] req1_b,
    input  logic [TAG_WIDTH-1:0]  req1_tag,
    output logic [WORD_WIDTH-1:0] mul_multiplicand,
    output logic [WORD_WIDTH-1:0] mul_multiplier,
    input  logic [WORD_WIDTH-1:0] mul_result,
    input  logic                  mul_overflow,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WORD_WIDTH-1:0] resp_result,
    output logic                  resp_overflow,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic                  resp_src,
    output logic                  busy
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(RESP_DEPTH + MUL_LATENCY + 1);

    function automatic logic [SW-1:0] count_ones(input logic [MUL_LATENCY-1:0] vec);
        logic [SW-1:0] total;
        total = '0;
        for (int i = 0; i < MUL_LATENCY; i++) begin
            total = total + SW'(vec[i]);
        end
        return total;
    endfunction

    logic [MUL_LATENCY-1:0] trk_valid_r;
    logic [MUL_LATENCY-1:0] trk_src_r;
    logic [TAG_WIDTH-1:0]   trk_tag_r [MUL_LATENCY];
    logic [WORD_WIDTH-1:0]  mem_res_r [RESP_DEPTH];
    logic [TAG_WIDTH-1:0]   mem_tag_r [RESP_DEPTH];
    logic [RESP_DEPTH-1:0]  mem_ovf_r;
    logic [RESP_DEPTH-1:0]  mem_src_r;
    logic [PW-1:0]          wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
    logic [CW-1:0]          count_r, count_nxt_s;
    logic                   rr_last_r;
    logic                   resp_valid_r, resp_ovf_r, resp_src_r, busy_r;
    logic [WORD_WIDTH-1:0]  resp_res_r;
    logic [TAG_WIDTH-1:0]   resp_tag_r;

    logic                   credit_ok_s, grant_valid_s, grant_id_s, push_s, pop_s;
    logic [TAG_WIDTH-1:0]   grant_tag_s;
    logic [MUL_LATENCY-1:0] trk_valid_nxt_s;
    logic [WORD_WIDTH-1:0]  head_res_s;
    logic [TAG_WIDTH-1:0]   head_tag_s;
    logic                   head_ovf_s, head_src_s;

    assign credit_ok_s     = (SW'(count_r) + count_ones(trk_valid_r)) < SW'(RESP_DEPTH);
    assign push_s          = trk_valid_r[MUL_LATENCY-1];
    assign pop_s           = resp_valid_r & resp_ready;
    assign trk_valid_nxt_s = {trk_valid_r[MUL_LATENCY-2:0], grant_valid_s};
    assign rd_ptr_nxt_s    = pop_s ? rd_ptr_r + PW'(1'b1) : rd_ptr_r;
    assign count_nxt_s     = count_r + CW'(push_s) - CW'(pop_s);

    // Same-cycle round-robin arbitration and operand steering.
    always_comb begin
        grant_valid_s    = 1'b0;
        grant_id_s       = 1'b0;
        grant_tag_s      = '0;
        mul_multiplicand = '0;
        mul_multiplier   = '0;
        if (rst_n && credit_ok_s) begin
            if (req0_valid && req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ~rr_last_r;
            end else if (req0_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b0;
            end else if (req1_valid) begin
                grant_valid_s = 1'b1;
                grant_id_s    = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_id_s    = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
        end
        if (grant_valid_s && grant_id_s) begin
            mul_multiplicand = req1_a;
            mul_multiplier   = req1_b;
            grant_tag_s      = req1_tag;
        end else if (grant_valid_s) begin
            mul_multiplicand = req0_a;
            mul_multiplier   = req0_b;
            grant_tag_s      = req0_tag;
        end else begin
            grant_tag_s      = '0;
        end
    end

    assign req0_ready = grant_valid_s & ~grant_id_s;
    assign req1_ready = grant_valid_s & grant_id_s;

    // Next head of the FIFO; bypasses the entry being pushed when it becomes the head.
    always_comb begin
        head_res_s = '0;
        head_tag_s = '0;
        head_ovf_s = 1'b0;
        head_src_s = 1'b0;
        if (count_nxt_s == '0) begin
            head_res_s = '0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_res_s = mul_result;
            head_ovf_s = mul_overflow;
            head_tag_s = trk_tag_r[MUL_LATENCY-1];
            head_src_s = trk_src_r[MUL_LATENCY-1];
        end else begin
            head_res_s = mem_res_r[rd_ptr_nxt_s];
            head_ovf_s = mem_ovf_r[rd_ptr_nxt_s];
            head_tag_s = mem_tag_r[rd_ptr_nxt_s];
            head_src_s = mem_src_r[rd_ptr_nxt_s];
        end
    end

    // In-flight tracker aligned with the multiplier pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trk_valid_r <= '0;
            trk_src_r   <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) trk_tag_r[i] <= '0;
        end else begin
            trk_valid_r <= trk_valid_nxt_s;
            trk_src_r   <= {trk_src_r[MUL_LATENCY-2:0], grant_id_s};
            for (int i = MUL_LATENCY - 1; i > 0; i--) trk_tag_r[i] <= trk_tag_r[i-1];
            trk_tag_r[0] <= grant_tag_s;
        end
    end

    // Response storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_res_r[wr_ptr_r] <= mul_result;
            mem_ovf_r[wr_ptr_r] <= mul_overflow;
            mem_tag_r[wr_ptr_r] <= trk_tag_r[MUL_LATENCY-1];
            mem_src_r[wr_ptr_r] <= trk_src_r[MUL_LATENCY-1];
        end
    end

    // FIFO control, round-robin state and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            rr_last_r    <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_res_r   <= '0;
            resp_ovf_r   <= 1'b0;
            resp_tag_r   <= '0;
            resp_src_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            if (grant_valid_s) rr_last_r <= grant_id_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            count_r      <= count_nxt_s;
            resp_valid_r <= (count_nxt_s != '0);
            resp_res_r   <= head_res_s;
            resp_ovf_r   <= head_ovf_s;
            resp_tag_r   <= head_tag_s;
            resp_src_r   <= head_src_s;
            busy_r       <= (|trk_valid_nxt_s) | (count_nxt_s != '0);
        end
    end

    assign resp_valid    = resp_valid_r;
    assign resp_result   = resp_res_r;
    assign resp_overflow = resp_ovf_r;
    assign resp_tag      = resp_tag_r;
    assign resp_src      = resp_src_r;
    assign busy          = busy_r;

    mul_issue_ctrl_chk #(.CW(CW), .RESP_DEPTH(RESP_DEPTH)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .count (count_r)
    );
endmodule

// Flags a capture into a full response FIFO, which credit gating must prevent.
module mul_issue_ctrl_chk #(
    parameter int CW         = 4,
    parameter int RESP_DEPTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic [CW-1:0] count
);
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (count == CW'(RESP_DEPTH))));
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a multiplier model and an in-order response scoreboard.
module tb_mul_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic [31:0] mul_multiplicand, mul_multiplier, mul_result;
    logic        mul_overflow;
    logic        resp_valid, resp_ready, resp_overflow, resp_src, busy;
    logic [31:0] resp_result;
    logic [3:0]  resp_tag;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic [3:0]  tag;
        logic        src;
    } exp_t;

    exp_t sb_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] pipe_res [5];
    logic        pipe_ovf [5];

    always #5 clk = ~clk;

    mul_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
        .mul_result(mul_result), .mul_overflow(mul_overflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_overflow(resp_overflow), .resp_tag(resp_tag), .resp_src(resp_src), .busy(busy)
    );

    // Five-stage non-stalling multiplier: result valid five edges after operands are presented.
    always @(posedge clk) begin
        logic [63:0] p;
        p = {32'd0, mul_multiplicand} * {32'd0, mul_multiplier};
        pipe_res[0] <= p[31:0];
        pipe_ovf[0] <= |p[63:32];
        for (int i = 1; i < 5; i++) begin
            pipe_res[i] <= pipe_res[i-1];
            pipe_ovf[i] <= pipe_ovf[i-1];
        end
    end
    assign mul_result   = pipe_res[4];
    assign mul_overflow = pipe_ovf[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] tag, input logic src);
        logic [63:0] p;
        exp_t e;
        p = {32'd0, a} * {32'd0, b};
        e.res = p[31:0];
        e.ovf = |p[63:32];
        e.tag = tag;
        e.src = src;
        return e;
    endfunction

    // Scoreboard: every accepted response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'd1, 64'd0);
            end else begin
                chk("resp", {26'd0, resp_result, resp_overflow, resp_tag, resp_src}, {26'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic src, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, input bit expect_resp);
        if (src) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tag;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tag;
        end
        #1;
        chk("issue_ready", {63'd0, src ? req1_ready : req0_ready}, 64'd1);
        if (expect_resp) sb_q.push_back(model(a, b, tag, src));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_sb_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int   lat;
        int   acc;
        int   seen;
        logic exp_src;
        rst_n = 1'b0; resp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd5; req0_tag = 4'd1;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_tag = 4'd0;
        tick();
        tick();
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_resp_data", {26'd0, resp_result, resp_overflow, resp_tag, resp_src}, 64'd0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // single op and minimum latency
        issue(1'b0, 32'd7, 32'd6, 4'd3, 1'b1);
        chk("busy_inflight", {63'd0, busy}, 64'd1);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd6);
        chk("single_result", {26'd0, resp_result, resp_overflow, resp_tag, resp_src},
            {26'd0, 32'd42, 1'b0, 4'd3, 1'b0});
        wait_idle();

        // overflow from req1
        issue(1'b1, 32'h0001_0000, 32'h0001_0000, 4'd9, 1'b1);
        wait_idle();

        // contention: rr_last is 1 after the req1 grant, so grants run 0,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            req0_valid = 1'b1; req0_a = 32'(i + 1);   req0_b = 32'd3; req0_tag = 4'(i);
            req1_valid = 1'b1; req1_a = 32'(i + 100); req1_b = 32'd5; req1_tag = 4'(i + 8);
            #1;
            exp_src = (i % 2 == 1);
            chk("cont_ready0", {63'd0, req0_ready}, {63'd0, !exp_src});
            chk("cont_ready1", {63'd0, req1_ready}, {63'd0, exp_src});
            if (exp_src) sb_q.push_back(model(req1_a, req1_b, req1_tag, 1'b1));
            else         sb_q.push_back(model(req0_a, req0_b, req0_tag, 1'b0));
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // backpressure: credit admits exactly RESP_DEPTH ops
        resp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            req0_valid = 1'b1; req0_a = 32'h100 + 32'(i); req0_b = 32'(i + 2); req0_tag = 4'(i);
            #1;
            chk("bp_ready", {63'd0, req0_ready}, {63'd0, acc < 8});
            if (acc < 8) begin
                sb_q.push_back(model(req0_a, req0_b, req0_tag, 1'b0));
                acc++;
            end
            tick();
        end
        chk("bp_accepted", 64'(acc), 64'd8);
        chk("bp_ready_low", {63'd0, req0_ready}, 64'd0);
        req0_valid = 1'b0;
        tick();
        chk("bp_head_valid", {63'd0, resp_valid}, 64'd1);
        chk("bp_head", {26'd0, resp_result, resp_overflow, resp_tag, resp_src}, {26'd0, sb_q[0]});
        tick(); tick(); tick();
        chk("bp_head_stable", {26'd0, resp_result, resp_overflow, resp_tag, resp_src}, {26'd0, sb_q[0]});
        resp_ready = 1'b1;
        wait_idle();

        // reset mid-operation drops all in-flight ops
        req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd13; req0_tag = 4'd2;
        tick();
        req0_a = 32'd17; req0_tag = 4'd4;
        tick();
        req0_a = 32'd19; req0_tag = 4'd6;
        tick();
        req0_valid = 1'b0;
        seen = 0;
        tick(); if (resp_valid) seen++;
        tick(); if (resp_valid) seen++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 12; i++) begin
            if (resp_valid) seen++;
            tick();
        end
        chk("midrst_no_resp", 64'(seen), 64'd0);
        chk("midrst_busy_after", {63'd0, busy}, 64'd0);
        issue(1'b0, 32'd12345, 32'd678, 4'd5, 1'b1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
